// File: rtl/msi_irq_ctrl_if.sv
// Handshake and status bundle between msi_irq_ctrl and its surroundings
// (interrupt sources on one side, the PCIe core MSI port on the other).
interface msi_irq_ctrl_if #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 16
);
  logic [N_SRC-1:0] irq_i;
  logic             msi_enabled;
  logic [2:0]       msi_mme;
  logic             msi_grant;
  logic             msi_request;
  logic [4:0]       msi_vector;
  logic [N_SRC-1:0] irq_pending_o;
  logic [CNT_W-1:0] coalesce_cnt;

  modport master (
    input  irq_i, msi_enabled, msi_mme, msi_grant,
    output msi_request, msi_vector, irq_pending_o, coalesce_cnt
  );

  modport slave (
    output irq_i, msi_enabled, msi_mme, msi_grant,
    input  msi_request, msi_vector, irq_pending_o, coalesce_cnt
  );
endinterface

// File: rtl/msi_irq_ctrl.sv
// Level-interrupt edge collector with round-robin arbitration feeding the
// PCIe core MSI request/grant handshake, one vector per source.
module msi_irq_ctrl #(
  parameter int N_SRC   = 4,
  parameter int GAP_CYC = 8,
  parameter int CNT_W   = 16
) (
  input  logic          axi_clk_pcie,
  input  logic          sys_rst,
  msi_irq_ctrl_if.master ctrl
);

  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] irq_prev_q, pend_q, pend_d, rise, clr;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d, rr_q, rr_d, pick;
  logic [4:0]       vec_q, vec_d;
  logic [7:0]       gap_q, gap_d;
  logic             grant_fire;

  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] r;
    logic             found;
    int               idx;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(ptr) + k) % N_SRC;
      if (!found && req[idx]) begin
        r     = SEL_W'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Sources beyond the allocated vector range share the top vector.
  function automatic logic [4:0] map_vec(input logic [SEL_W-1:0] sel,
                                         input logic [2:0] mme);
    logic [2:0] m;
    logic [5:0] maxv;
    m    = (mme > 3'd5) ? 3'd5 : mme;
    maxv = (6'd1 << m) - 6'd1;
    return (6'(sel) > maxv) ? maxv[4:0] : 5'(sel);
  endfunction

  function automatic int unsigned popcnt(input logic [N_SRC-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < N_SRC; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input int unsigned n);
    logic [CNT_W+4:0] s;
    s = {5'b0, a} + (CNT_W+5)'(n);
    return (s > {5'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  assign rise       = ctrl.irq_i & ~irq_prev_q;
  assign grant_fire = (state_q == REQ) && ctrl.msi_grant;
  assign pick       = rr_pick(pend_q, rr_q);

  always_comb begin
    clr = '0;
    if (grant_fire) clr[sel_q] = 1'b1;
  end

  // A rise on the source being granted re-arms it without counting as coalesced.
  assign pend_d = (pend_q & ~clr) | rise;
  assign cnt_d  = sat_add(cnt_q, popcnt(rise & pend_q & ~clr));

  always_ff @(posedge axi_clk_pcie or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ctrl.msi_enabled && (|pend_q)) state_d = REQ;
      REQ: begin
        if (ctrl.msi_grant)         state_d = (GAP_CYC == 0) ? IDLE : GAP;
        else if (!ctrl.msi_enabled) state_d = IDLE;
      end
      GAP: if (gap_q <= 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl.msi_request = (state_q == REQ);
  end

  always_comb begin
    sel_d = sel_q;
    vec_d = vec_q;
    rr_d  = rr_q;
    gap_d = gap_q;
    if (state_q == IDLE && state_d == REQ) begin
      sel_d = pick;
      vec_d = map_vec(pick, ctrl.msi_mme);
    end
    if (grant_fire) begin
      rr_d  = (sel_q == SEL_W'(N_SRC - 1)) ? '0 : sel_q + 1'b1;
      gap_d = 8'(GAP_CYC);
    end else if (state_q == GAP) begin
      gap_d = gap_q - 8'd1;
    end
  end

  always_ff @(posedge axi_clk_pcie or posedge sys_rst) begin
    if (sys_rst) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      vec_q      <= '0;
      rr_q       <= '0;
      gap_q      <= '0;
    end else begin
      irq_prev_q <= ctrl.irq_i;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      vec_q      <= vec_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
    end
  end

  assign ctrl.msi_vector    = vec_q;
  assign ctrl.irq_pending_o = pend_q;
  assign ctrl.coalesce_cnt  = cnt_q;

endmodule
